// File: rtl/parity_frame_receiver.sv
// ----------------------------------------------------------------------------
// parity_frame_receiver
//   Receives 7-bit serial frames, one bit per clk cycle:
//     start(0), D0, D1, D2, D3, parity, stop(1)
//   For each frame it reports the 4-bit data word, a parity error flag and a
//   framing (stop-bit) error flag. A frame may start in the cycle right after
//   the previous stop bit. A low stop bit parks the FSM in WAIT_IDLE until the
//   line returns high, so that low level is never taken as a new start bit.
//
// Parameters
//   ODD_PARITY : 0 = even parity (parity bit = XOR of data),
//                1 = odd parity  (parity bit = XNOR of data)
//
// Optional feature (macro PARITY_ERR_COUNT_EN)
//   Adds err_cnt[7:0]. It counts frames reported with perr|ferr, saturates at
//   8'hFF and is cleared only by rst. Without the macro there is no port and
//   no counter.
//
// Ports
//   clk     in   clock; all state updates on its rising edge
//   rst     in   synchronous active-high reset
//   sin     in   serial line, idle level 1
//   dout    out  [3:0] last received data word, D0 in bit 0
//   dvalid  out  one-cycle pulse for a completed frame
//   perr    out  parity error of the last frame (qualified by dvalid)
//   ferr    out  framing error of the last frame (qualified by dvalid)
//   busy    out  high whenever the FSM is not in IDLE
//   err_cnt out  [7:0] saturating error counter (PARITY_ERR_COUNT_EN only)
// ----------------------------------------------------------------------------
module parity_frame_receiver #(
    parameter int ODD_PARITY = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    output logic [3:0] dout,
    output logic       dvalid,
    output logic       perr,
    output logic       ferr,
    output logic       busy
`ifdef PARITY_ERR_COUNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam logic L_ODD = (ODD_PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t     r_state;
    logic [1:0] r_idx;
    logic [3:0] r_cap;
    logic       r_perr_pend;  // parity result held across the STOP cycle
    logic [3:0] r_dout;
    logic       r_dvalid;
    logic       r_perr;
    logic       r_ferr;
    logic       r_busy;
`ifdef PARITY_ERR_COUNT_EN
    logic [7:0] r_err_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= 2'd0;
            r_cap       <= 4'h0;
            r_perr_pend <= 1'b0;
            r_dout      <= 4'h0;
            r_dvalid    <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_busy      <= 1'b0;
`ifdef PARITY_ERR_COUNT_EN
            r_err_cnt   <= 8'h00;
`endif
        end else begin
            r_dvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!sin) begin
                        r_state <= S_DATA;
                        r_idx   <= 2'd0;
                        r_busy  <= 1'b1;
                    end
                end
                S_DATA: begin
                    r_cap[r_idx] <= sin;
                    r_idx        <= r_idx + 2'd1;
                    if (r_idx == 2'd3) r_state <= S_PARITY;
                end
                S_PARITY: begin
                    // Nonzero when the received parity bit disagrees with the data.
                    r_perr_pend <= (^r_cap) ^ sin ^ L_ODD;
                    r_state     <= S_STOP;
                end
                S_STOP: begin
                    r_dout   <= r_cap;
                    r_perr   <= r_perr_pend;
                    r_ferr   <= ~sin;
                    r_dvalid <= 1'b1;
`ifdef PARITY_ERR_COUNT_EN
                    // Updated together with dvalid so the count is current while it is high.
                    if ((r_perr_pend | ~sin) && (r_err_cnt != 8'hFF))
                        r_err_cnt <= r_err_cnt + 8'd1;
`endif
                    // A low stop bit must not double as the next start bit.
                    r_state <= sin ? S_IDLE : S_WAIT_IDLE;
                    r_busy  <= ~sin;
                end
                S_WAIT_IDLE: begin
                    if (sin) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dout   = r_dout;
    assign dvalid = r_dvalid;
    assign perr   = r_perr;
    assign ferr   = r_ferr;
    assign busy   = r_busy;
`ifdef PARITY_ERR_COUNT_EN
    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: doc/parity_frame_receiver.md
PARITY_FRAME_RECEIVER -- requirements
Module: parity_frame_receiver

Interface
REQ-001 SHALL have parameter ODD_PARITY, default 0, where 0 means even parity (parity bit = XOR of data) and 1 means odd parity (parity bit = XNOR of data).
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port sin, input, 1, serial line carrying one bit per clk cycle; idle level is 1.
REQ-005 SHALL have port dout, output, 4, last received data word, with D0 in bit 0.
REQ-006 SHALL have port dvalid, output, 1, a one-cycle pulse marking a completed frame.
REQ-007 SHALL have port perr, output, 1, parity mismatch flag qualified by dvalid.
REQ-008 SHALL have port ferr, output, 1, framing (stop-bit) error flag qualified by dvalid.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-010 SHALL accept frames with this bit order: start(0), D0, D1, D2, D3, parity, stop(1), for 7 bits in 7 consecutive cycles.
REQ-011 SHALL use the FSM states IDLE, DATA, PARITY, STOP and WAIT_IDLE.
REQ-012 In IDLE, sampling sin=0 SHALL move the FSM to DATA with the bit index cleared; sin=1 SHALL keep it in IDLE.
REQ-013 In DATA, SHALL shift sin into bit [index] of a 4-bit capture register and increment the 2-bit index, moving to PARITY after index 3.
REQ-014 In PARITY, SHALL register the computed error (^data ^ sin ^ ODD_PARITY) and then move to STOP.
REQ-015 In STOP, SHALL load dout from the capture register, set perr, set ferr = ~sin, and pulse dvalid in the next cycle.
REQ-016 Latency: dvalid SHALL go high exactly 1 cycle after the stop bit is sampled, which is 7 cycles after the start bit is sampled.
REQ-017 After STOP with sin=1, SHALL go to IDLE; a start bit in the very next cycle SHALL be accepted (back-to-back frames, no gap required).
REQ-018 After STOP with sin=0 (framing error), SHALL go to WAIT_IDLE and stay there until sin=1 is sampled, then go to IDLE; the 0 SHALL NOT be treated as a start bit.
REQ-019 dout, perr and ferr SHALL hold their values until the next dvalid.
REQ-020 dvalid SHALL be low in every cycle except the single cycle after a STOP sample.
REQ-021 perr and ferr SHALL both be reported when both conditions occur in the same frame.

Reset
REQ-022 When rst=1 at a clock edge, SHALL force state=IDLE, index=0, capture=0, dout=4'h0, dvalid=0, perr=0, ferr=0, busy=0, and err_cnt=8'h00 when present.
REQ-023 Asserting reset mid-frame SHALL discard the partial frame with no dvalid, and the first sin=0 after release SHALL be treated as a start bit.
REQ-024 rst SHALL have priority over all other events in the same cycle.

Configuration
REQ-025 The feature SHALL be controlled by macro PARITY_ERR_COUNT_EN.
REQ-026 With PARITY_ERR_COUNT_EN defined, SHALL add output err_cnt [7:0], which increments on each dvalid with perr|ferr, saturates at 8'hFF, and is cleared only by rst.
REQ-027 Without PARITY_ERR_COUNT_EN, SHALL have no err_cnt port and no counter logic, with all other behaviour identical.

Verification
REQ-028 Reset, then frame 0,1,0,1,1,1,1 (data 4'hD, parity 1, even) -> dvalid 1 cycle after stop, dout=4'hD, perr=0, ferr=0.
REQ-029 Frame data 4'h3 with parity bit 1 (even mode) -> dvalid with perr=1, ferr=0, dout=4'h3, and err_cnt 0->1 when enabled.
REQ-030 Frame data 4'hA with correct parity and stop=0, then sin held at 0 for 3 cycles, then 1 -> ferr=1, busy stays high until sin=1, and no spurious frame is received.
REQ-031 Two back-to-back frames 4'h1 then 4'hE with no idle gap -> two dvalid pulses 7 cycles apart with correct dout each.
REQ-032 rst=1 pulsed after D1 of a frame, then a full frame 4'h7 -> no dvalid for the aborted frame and dout=4'h7 for the new one.
REQ-033 ODD_PARITY=1 with 300 frames containing bad parity (PARITY_ERR_COUNT_EN defined) -> perr set on every frame and err_cnt saturates at 8'hFF.
